// File: rtl/exe_stage.sv
// exe_stage: EXE stage of the 5-stage ARM pipeline.
//   Builds Val2 from the shifter operand, runs the ALU, computes the branch
//   target, owns the NZCV status register and latches the EXE/MEM register.
// Ports:
//   clk, rst (async, active-low), freeze (hold EXE/MEM + SR)
//   ID/EXE inputs : wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, pc_in,
//                   exe_cmd_in, val_rn_in, val_rm_in, imm_in, shift_operand,
//                   signed_imm_24, dest_in
//   branch_taken, branch_addr : combinational, same cycle
//   status {N,Z,C,V}, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest : registered
// Optional: `define FORWARDING_EN adds sel_src1/sel_src2/mem_fwd_val/wb_fwd_val
//   operand forwarding muxes in front of the ALU and the store-data path.
module exe_stage #(
  parameter int DW    = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [DW-1:0]    pc_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      signed_imm_24,
  input  logic [RADDR-1:0] dest_in,
`ifdef FORWARDING_EN
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [DW-1:0]    mem_fwd_val,
  input  logic [DW-1:0]    wb_fwd_val,
`endif
  output logic             branch_taken,
  output logic [DW-1:0]    branch_addr,
  output logic [3:0]       status,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [DW-1:0]    alu_res,
  output logic [DW-1:0]    val_rm,
  output logic [RADDR-1:0] dest
);

  typedef enum logic [3:0] {
    OP_MOV = 4'b0001, OP_MVN = 4'b1001, OP_ADD = 4'b0010, OP_ADC = 4'b0011,
    OP_SUB = 4'b0100, OP_SBC = 4'b0101, OP_AND = 4'b0110, OP_ORR = 4'b0111,
    OP_EOR = 4'b1000
  } alu_op_e;

  logic [DW-1:0] a, rm, val2, res, rot_imm, sh_rm, imm_base;
  logic [DW:0]   sum;
  logic [3:0]    nzcv;
  logic          upd, cin, mem_op;
  logic [4:0]    sh_amt;
  logic [3:0]    cmd;

  // ---- operand selection ----
`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   a = mem_fwd_val;
      2'b10:   a = wb_fwd_val;
      default: a = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   rm = mem_fwd_val;
      2'b10:   rm = wb_fwd_val;
      default: rm = val_rm_in;
    endcase
  end
`else
  assign a  = val_rn_in;
  assign rm = val_rm_in;
`endif

  // ---- branch (0-cycle) ----
  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(DW-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

  // ---- Val2 generation ----
  // Rotates: a shift by DW yields 0, so a zero amount collapses to identity.
  assign imm_base = {{(DW-8){1'b0}}, shift_operand[7:0]};
  assign rot_imm  = (imm_base >> {shift_operand[11:8], 1'b0}) |
                    (imm_base << (DW - {shift_operand[11:8], 1'b0}));
  assign sh_amt   = shift_operand[11:7];

  always_comb begin
    sh_rm = rm;
    if (sh_amt != 5'd0) begin
      case (shift_operand[6:5])
        2'b00: sh_rm = rm << sh_amt;
        2'b01: sh_rm = rm >> sh_amt;
        2'b10: sh_rm = $signed(rm) >>> sh_amt;
        2'b11: sh_rm = (rm >> sh_amt) | (rm << (DW - sh_amt));
      endcase
    end
  end

  assign mem_op = mem_r_en_in | mem_w_en_in;
  assign val2   = imm_in ? rot_imm :
                  mem_op ? {{(DW-12){1'b0}}, shift_operand} : sh_rm;

  // ---- ALU ----
  // Subtracts are a + ~b + carry so C comes out directly as NOT borrow.
  assign cin = status[1];
  assign cmd = mem_op ? OP_ADD : exe_cmd_in;

  always_comb begin
    sum  = '0;
    res  = '0;
    upd  = 1'b1;
    nzcv = status;
    case (cmd)
      OP_MOV: res = val2;
      OP_MVN: res = ~val2;
      OP_AND: res = a & val2;
      OP_ORR: res = a | val2;
      OP_EOR: res = a ^ val2;
      OP_ADD: sum = {1'b0, a} + {1'b0, val2};
      OP_ADC: sum = {1'b0, a} + {1'b0, val2} + {{DW{1'b0}}, cin};
      OP_SUB: sum = {1'b0, a} + {1'b0, ~val2} + {{DW{1'b0}}, 1'b1};
      OP_SBC: sum = {1'b0, a} + {1'b0, ~val2} + {{DW{1'b0}}, cin};
      default: upd = 1'b0;
    endcase
    case (cmd)
      OP_ADD, OP_ADC: begin
        res     = sum[DW-1:0];
        nzcv[1] = sum[DW];
        nzcv[0] = (a[DW-1] == val2[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      OP_SUB, OP_SBC: begin
        res     = sum[DW-1:0];
        nzcv[1] = sum[DW];
        nzcv[0] = (a[DW-1] != val2[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      default: ;
    endcase
    nzcv[3] = res[DW-1];
    nzcv[2] = (res == '0);
  end

  // ---- EXE/MEM register and SR ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status   <= 4'b0000;
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      alu_res  <= '0;
      val_rm   <= '0;
      dest     <= '0;
    end else if (!freeze) begin
      if (s_in && upd) status <= nzcv;
      wb_en    <= wb_en_in;
      mem_r_en <= mem_r_en_in;
      mem_w_en <= mem_w_en_in;
      alu_res  <= res;
      val_rm   <= rm;
      dest     <= dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized + directed self-checking bench for exe_stage,
// compared against an arithmetic reference model of the EXE stage.
module tb_exe_stage;
  logic        clk = 1'b0, rst = 1'b0, freeze, wb_en_in, mem_r_en_in, mem_w_en_in;
  logic        b_in, s_in, imm_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [3:0]  exe_cmd_in;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic        branch_taken, wb_en, mem_r_en, mem_w_en;
  logic [31:0] branch_addr, alu_res, val_rm;
  logic [3:0]  status, dest;
`ifdef FORWARDING_EN
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_val, wb_fwd_val;
`endif

  int n_chk = 0, n_fail = 0;

  // reference state
  logic [3:0]  m_sr, m_dest;
  logic [31:0] m_alu, m_rm;
  logic        m_wb, m_mr, m_mw;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .b_in(b_in),
    .s_in(s_in), .pc_in(pc_in), .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in),
    .val_rm_in(val_rm_in), .imm_in(imm_in), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest_in(dest_in),
`ifdef FORWARDING_EN
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
`endif
    .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .dest(dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                         input logic [11:0] op, input logic [31:0] r);
    int amt;
    logic [31:0] base;
    base = {24'b0, op[7:0]};
    amt  = int'(op[11:7]);
    if (imm) return ror32(base, 2 * int'(op[11:8]));
    if (mem) return {20'b0, op};
    if (amt == 0) return r;
    case (op[6:5])
      2'b00:   return r << amt;
      2'b01:   return r >> amt;
      2'b10:   return 32'($signed(r) >>> amt);
      default: return ror32(r, amt);
    endcase
  endfunction

  // Arithmetic done in 64-bit integers: carry from the unsigned sum/compare,
  // overflow from the signed result leaving the 32-bit range.
  task automatic alu_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sr, output logic [31:0] res,
                           output logic [3:0] f, output bit ok);
    longint unsigned ua, ub, u, ci, bw;
    longint sa, sb, sx;
    logic c, v;
    ua = a; ub = b; ci = sr[1]; bw = 1 - ci;
    sa = $signed(a); sb = $signed(b);
    c = sr[1]; v = sr[0]; ok = 1; u = 0; sx = 0; res = 0;
    case (cmd)
      4'b0001: res = b;
      4'b1001: res = ~b;
      4'b0110: res = a & b;
      4'b0111: res = a | b;
      4'b1000: res = a ^ b;
      4'b0010: begin u = ua + ub;      c = u[32];           sx = sa + sb; end
      4'b0011: begin u = ua + ub + ci; c = u[32];           sx = sa + sb + longint'(ci); end
      4'b0100: begin u = ua - ub;      c = (ua >= ub);      sx = sa - sb; end
      4'b0101: begin u = ua - ub - bw; c = (ua >= ub + bw); sx = sa - sb - longint'(bw); end
      default: ok = 0;
    endcase
    if (cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101}) begin
      res = u[31:0];
      v = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
    end
    f = ok ? {res[31], res == 32'd0, c, v} : sr;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_alu"},  alu_res,  m_alu);
    chk({tag, "_sr"},   {28'b0, status}, {28'b0, m_sr});
    chk({tag, "_rm"},   val_rm,   m_rm);
    chk({tag, "_dest"}, {28'b0, dest}, {28'b0, m_dest});
    chk({tag, "_ctl"},  {29'b0, wb_en, mem_r_en, mem_w_en}, {29'b0, m_wb, m_mr, m_mw});
  endtask

  // One clock: check branch outputs, predict, clock, compare registers.
  task automatic step(input string tag);
    logic [31:0] a, r, v2, res, off;
    logic [3:0]  f, cmd;
    bit ok;
    #1;
    off = {{8{signed_imm_24[23]}}, signed_imm_24};
    chk({tag, "_btk"}, {31'b0, branch_taken}, {31'b0, b_in});
    chk({tag, "_badr"}, branch_addr, pc_in + off * 4);
    a = val_rn_in; r = val_rm_in;
`ifdef FORWARDING_EN
    if (sel_src1 == 2'b01) a = mem_fwd_val; else if (sel_src1 == 2'b10) a = wb_fwd_val;
    if (sel_src2 == 2'b01) r = mem_fwd_val; else if (sel_src2 == 2'b10) r = wb_fwd_val;
`endif
    v2  = m_val2(imm_in, mem_r_en_in | mem_w_en_in, shift_operand, r);
    cmd = (mem_r_en_in | mem_w_en_in) ? 4'b0010 : exe_cmd_in;
    alu_model(cmd, a, v2, m_sr, res, f, ok);
    @(posedge clk);
    if (!freeze) begin
      if (s_in) m_sr = f;
      m_alu = res; m_rm = r; m_dest = dest_in;
      m_wb = wb_en_in; m_mr = mem_r_en_in; m_mw = mem_w_en_in;
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic clr();
    freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
    imm_in = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; exe_cmd_in = 0;
    shift_operand = 0; signed_imm_24 = 0; dest_in = 0;
`ifdef FORWARDING_EN
    sel_src1 = 0; sel_src2 = 0; mem_fwd_val = 0; wb_fwd_val = 0;
`endif
  endtask

  task automatic rnd();
    freeze = ($urandom_range(0, 4) == 0);
    wb_en_in = 1'($urandom); b_in = 1'($urandom); s_in = 1'($urandom);
    mem_r_en_in = ($urandom_range(0, 3) == 0);
    mem_w_en_in = !mem_r_en_in && ($urandom_range(0, 3) == 0);
    imm_in = 1'($urandom); pc_in = $urandom; exe_cmd_in = 4'($urandom);
    val_rn_in = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
    val_rm_in = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
    shift_operand = 12'($urandom); signed_imm_24 = 24'($urandom); dest_in = 4'($urandom);
`ifdef FORWARDING_EN
    sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
    mem_fwd_val = $urandom; wb_fwd_val = $urandom;
`endif
  endtask

  task automatic m_reset();
    m_sr = 0; m_alu = 0; m_rm = 0; m_dest = 0; m_wb = 0; m_mr = 0; m_mw = 0;
  endtask

  initial begin
    logic [31:0] hold_alu;
    logic [3:0]  hold_sr;
    clr(); m_reset();
    #2 chk_regs("rst0");
    @(negedge clk) rst = 1;

    // ADD overflow into sign bit
    exe_cmd_in = 4'b0010; val_rn_in = 32'h7FFFFFFF; imm_in = 1; shift_operand = 12'h001; s_in = 1;
    step("add_ovf");
    chk("add_ovf_res", alu_res, 32'h80000000);
    chk("add_ovf_nzcv", {28'b0, status}, 32'h9);

    // SUB to zero, then ADC consuming the carry
    exe_cmd_in = 4'b0100; val_rn_in = 5; shift_operand = 12'h005;
    step("sub0");
    chk("sub0_res", alu_res, 0);
    chk("sub0_nzcv", {28'b0, status}, 32'h6);
    exe_cmd_in = 4'b0011; val_rn_in = 1; val_rm_in = 1; imm_in = 0; shift_operand = 0; s_in = 0;
    step("adc");
    chk("adc_res", alu_res, 3);

    // rotated immediate through MOV, SR held
    exe_cmd_in = 4'b0001; imm_in = 1; shift_operand = 12'h4FF;
    step("mov_rot");
    chk("mov_rot_res", alu_res, 32'hFF000000);
    chk("mov_rot_sr", {28'b0, status}, 32'h6);

    // branch target, same cycle
    pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE; b_in = 1;
    #1 chk("br_addr", branch_addr, 32'hF8);
    chk("br_taken", {31'b0, branch_taken}, 1);
    step("br");

    // freeze for 3 cycles
    hold_alu = alu_res; hold_sr = status;
    for (int i = 0; i < 3; i++) begin
      rnd(); freeze = 1; s_in = 1;
      step("frz");
      chk("frz_alu", alu_res, hold_alu);
      chk("frz_sr", {28'b0, status}, {28'b0, hold_sr});
    end

`ifdef FORWARDING_EN
    clr(); sel_src1 = 2'b01; mem_fwd_val = 9; exe_cmd_in = 4'b0010;
    imm_in = 1; shift_operand = 12'h001;
    step("fwd");
    chk("fwd_res", alu_res, 10);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rnd();
      step("rnd");
    end

    // asynchronous reset mid-cycle with busy inputs
    rnd(); freeze = 0; s_in = 1; exe_cmd_in = 4'b1001;
    step("pre_rst");
    #2 rst = 0;
    #1 m_reset();
    chk_regs("arst");
    #1 rst = 1;
    for (int i = 0; i < 50; i++) begin
      rnd();
      step("post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
